aether_cmd_decoder: RTL and testbench

//  Front-end of aether_engine: samples the 24-bit host command word every clk_i cycle, queues non-NOP

---
 rtl/aether_pkg.sv | 45 ++++
 rtl/aether_cmd_fifo.sv | 75 +++++++
 rtl/aether_cmd_decoder.sv | 179 +++++++++++++++++
 tb/tb_aether_cmd_decoder.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aether_pkg.sv
// Shared types for the aether_engine command front-end: command word layout,
// opcode / task / reset sub-code encodings and a bypass-detect helper.
package aether_pkg;

  localparam int CmdWidth = 24;
  localparam int ArgWidth = 16;

  typedef enum logic [3:0] {
    NOP        = 4'h0,
    RESET      = 4'h1,
    WRITE_REG  = 4'h2,
    READ_REG   = 4'h3,
    START_TASK = 4'h4
  } opcode_e;

  typedef enum logic [3:0] {
    LOAD_CONV_WEIGHTS = 4'h0,
    LOAD_CONV_DATA    = 4'h1,
    RUN_CONV          = 4'h2,
    RUN_DENSE         = 4'h3,
    WRITE_TO_MEM      = 4'h4,
    READ_FROM_MEM     = 4'h5
  } task_e;

  typedef enum logic [3:0] {
    RST_ALL          = 4'h0,
    RST_CONV         = 4'h1,
    RST_CONV_WEIGHTS = 4'h2,
    TASK_RAM         = 4'h3
  } rst_e;

  // Fields are plain bit vectors so that unknown opcodes survive the queue
  // and can be discarded by the decoder.
  typedef struct packed {
    logic [3:0]  opcode;
    logic [3:0]  sub;
    logic [15:0] arg;
  } cmd_t;

  // RESET/RST_ALL skips the queue and takes effect immediately.
  function automatic logic is_rst_all(input cmd_t c);
    return (c.opcode == RESET) && (c.sub == RST_ALL);
  endfunction

endpackage

// File: rtl/aether_cmd_fifo.sv
// Synchronous command FIFO with flush. The head entry is presented
// combinationally so the decoder can capture it in the same edge it pops.
// full/empty are flops computed from the next occupancy.
module aether_cmd_fifo
  import aether_pkg::*;
#(
  parameter int Depth = 8
) (
  input  logic clk,
  input  logic srst,
  input  logic flush,
  input  logic push,
  input  cmd_t push_data,
  input  logic pop,
  output cmd_t pop_data,
  output logic full,
  output logic empty
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  cmd_t            mem [Depth];
  logic [PtrW-1:0] wr_ptr_reg;
  logic [PtrW-1:0] rd_ptr_reg;
  logic [CntW-1:0] count_reg;
  logic [CntW-1:0] count_next;
  logic            full_reg;
  logic            empty_reg;
  logic            do_pop;
  logic            do_push;

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_pop  = pop && !empty_reg;
  assign do_push = push && (!full_reg || do_pop);

  // Next occupancy drives the registered full/empty flags.
  always_comb begin
    count_next = count_reg;
    if (flush) begin
      count_next = '0;
    end else begin
      count_next = count_reg + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Storage write; pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer, count and flag state.
  always_ff @(posedge clk) begin
    if (srst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      full_reg  <= (count_next == CntW'(Depth));
      empty_reg <= (count_next == '0);
    end
  end

  assign pop_data = mem[rd_ptr_reg];
  assign full     = full_reg;
  assign empty    = empty_reg;

endmodule

// File: rtl/aether_cmd_decoder.sv
// Host command front-end: queues non-NOP command words and dispatches them
// one at a time to the register file, reset fabric and task units.
// RESET/RST_ALL bypasses the queue and aborts everything in flight.
module aether_cmd_decoder
  import aether_pkg::*;
#(
  parameter int CmdFifoDepth = 8,
  parameter int ArgWidth     = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CmdWidth-1:0] cmd_i,
  output logic                buffer_full_o,
  output logic                overflow_o,
  output logic [3:0]          rst_sel_o,
  output logic                rst_pulse_o,
  output logic                reg_wr_en_o,
  output logic [3:0]          reg_addr_o,
  output logic [ArgWidth-1:0] reg_wr_data_o,
  output logic                reg_rd_en_o,
  input  logic [ArgWidth-1:0] reg_rd_data_i,
  output logic [ArgWidth-1:0] data_o,
  output logic                task_valid_o,
  output logic [3:0]          task_id_o,
  output logic [ArgWidth-1:0] task_arg_o,
  input  logic                task_ready_i,
  input  logic                task_done_i,
  output logic                interrupt_o
);

  typedef enum logic [2:0] {IDLE, EXEC, DISPATCH, BUSY, RD_WAIT} state_e;

  state_e              state_reg;
  cmd_t                cmd_reg;
  cmd_t                cmd_in;
  cmd_t                fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  logic                bypass;
  logic                drop;
  logic                overflow_reg;
  logic [3:0]          rst_sel_reg;
  logic                rst_pulse_reg;
  logic                reg_wr_en_reg;
  logic [3:0]          reg_addr_reg;
  logic [ArgWidth-1:0] reg_wr_data_reg;
  logic                reg_rd_en_reg;
  logic [ArgWidth-1:0] data_reg;
  logic                task_valid_reg;
  logic [3:0]          task_id_reg;
  logic [ArgWidth-1:0] task_arg_reg;
  logic                interrupt_reg;

  assign cmd_in    = cmd_i;
  assign bypass    = is_rst_all(cmd_in);
  assign fifo_push = (cmd_in != '0) && !bypass;
  assign fifo_pop  = (state_reg == IDLE) && !fifo_empty && !bypass;
  assign drop      = fifo_push && fifo_full && !fifo_pop;

  aether_cmd_fifo #(
    .Depth(CmdFifoDepth)
  ) u_fifo (
    .clk      (clk_i),
    .srst     (rst_i),
    .flush    (bypass),
    .push     (fifo_push),
    .push_data(cmd_in),
    .pop      (fifo_pop),
    .pop_data (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Decoder FSM with every output registered; the bypass reset overrides all handshakes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg       <= IDLE;
      cmd_reg         <= '0;
      overflow_reg    <= 1'b0;
      rst_sel_reg     <= '0;
      rst_pulse_reg   <= 1'b0;
      reg_wr_en_reg   <= 1'b0;
      reg_addr_reg    <= '0;
      reg_wr_data_reg <= '0;
      reg_rd_en_reg   <= 1'b0;
      data_reg        <= '0;
      task_valid_reg  <= 1'b0;
      task_id_reg     <= '0;
      task_arg_reg    <= '0;
      interrupt_reg   <= 1'b0;
    end else if (bypass) begin
      state_reg      <= IDLE;
      overflow_reg   <= 1'b0;
      rst_sel_reg    <= RST_ALL;
      rst_pulse_reg  <= 1'b1;
      reg_wr_en_reg  <= 1'b0;
      reg_rd_en_reg  <= 1'b0;
      task_valid_reg <= 1'b0;
      interrupt_reg  <= 1'b0;
    end else begin
      rst_pulse_reg <= 1'b0;
      reg_wr_en_reg <= 1'b0;
      reg_rd_en_reg <= 1'b0;
      interrupt_reg <= 1'b0;
      if (drop) overflow_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (!fifo_empty) begin
            cmd_reg   <= fifo_head;
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          state_reg <= IDLE;
          case (cmd_reg.opcode)
            WRITE_REG: begin
              reg_wr_en_reg   <= 1'b1;
              reg_addr_reg    <= cmd_reg.sub;
              reg_wr_data_reg <= cmd_reg.arg;
            end
            READ_REG: begin
              reg_rd_en_reg <= 1'b1;
              reg_addr_reg  <= cmd_reg.sub;
              state_reg     <= RD_WAIT;
            end
            RESET: begin
              rst_pulse_reg <= 1'b1;
              rst_sel_reg   <= cmd_reg.sub;
            end
            START_TASK: begin
              // Sub-codes past the last task unit are discarded like unknown opcodes.
              if (cmd_reg.sub <= READ_FROM_MEM) begin
                task_valid_reg <= 1'b1;
                task_id_reg    <= cmd_reg.sub;
                task_arg_reg   <= cmd_reg.arg;
                state_reg      <= DISPATCH;
              end
            end
            default: ;
          endcase
        end
        RD_WAIT: begin
          data_reg  <= reg_rd_data_i;
          state_reg <= IDLE;
        end
        DISPATCH: begin
          if (task_ready_i) begin
            task_valid_reg <= 1'b0;
            state_reg      <= BUSY;
          end
        end
        BUSY: begin
          if (task_done_i) begin
            interrupt_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign buffer_full_o = fifo_full;
  assign overflow_o    = overflow_reg;
  assign rst_sel_o     = rst_sel_reg;
  assign rst_pulse_o   = rst_pulse_reg;
  assign reg_wr_en_o   = reg_wr_en_reg;
  assign reg_addr_o    = reg_addr_reg;
  assign reg_wr_data_o = reg_wr_data_reg;
  assign reg_rd_en_o   = reg_rd_en_reg;
  assign data_o        = data_reg;
  assign task_valid_o  = task_valid_reg;
  assign task_id_o     = task_id_reg;
  assign task_arg_o    = task_arg_reg;
  assign interrupt_o   = interrupt_reg;

endmodule

// File: tb/tb_aether_cmd_decoder.sv
// Bench for aether_cmd_decoder: directed scenarios with cycle-exact checks,
// then randomized command bursts checked against an in-order event model.
module tb_aether_cmd_decoder;
  import aether_pkg::*;

  localparam int EV_W = 1, EV_R = 2, EV_D = 3, EV_T = 4, EV_I = 5, EV_P = 6;

  typedef struct {
    int kind;
    int a;
    int d;
    int cyc;
  } ev_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [23:0] cmd_i;
  logic        buffer_full_o, overflow_o, rst_pulse_o, reg_wr_en_o, reg_rd_en_o;
  logic [3:0]  rst_sel_o, reg_addr_o, task_id_o;
  logic [15:0] reg_wr_data_o, data_o, task_arg_o, reg_rd_data_i;
  logic        task_valid_o, task_ready_i, task_done_i, interrupt_o;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  ev_t obs[$];
  ev_t exp_q[$];
  logic [15:0] stub_val [16];
  bit prev_rd, prev_valid, auto_resp, busy_pend;
  logic [3:0] cap_id;
  logic [15:0] cap_arg;
  int stab_viol = 0;
  int rdy_cnt = 0;
  int done_cnt = 0;

  aether_cmd_decoder #(.CmdFifoDepth(8), .ArgWidth(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cmd_i(cmd_i),
    .buffer_full_o(buffer_full_o), .overflow_o(overflow_o),
    .rst_sel_o(rst_sel_o), .rst_pulse_o(rst_pulse_o),
    .reg_wr_en_o(reg_wr_en_o), .reg_addr_o(reg_addr_o), .reg_wr_data_o(reg_wr_data_o),
    .reg_rd_en_o(reg_rd_en_o), .reg_rd_data_i(reg_rd_data_i), .data_o(data_o),
    .task_valid_o(task_valid_o), .task_id_o(task_id_o), .task_arg_o(task_arg_o),
    .task_ready_i(task_ready_i), .task_done_i(task_done_i), .interrupt_o(interrupt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] mk(input logic [3:0] op, input logic [3:0] sub, input logic [15:0] arg);
    return {op, sub, arg};
  endfunction

  // One clock: sample outputs #1 after the edge, log events, emulate the register file and task unit.
  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
    if (reg_wr_en_o) obs.push_back('{kind: EV_W, a: int'(reg_addr_o), d: int'(reg_wr_data_o), cyc: cyc});
    if (prev_rd) obs.push_back('{kind: EV_D, a: 0, d: int'(data_o), cyc: cyc});
    if (reg_rd_en_o) obs.push_back('{kind: EV_R, a: int'(reg_addr_o), d: 0, cyc: cyc});
    prev_rd = reg_rd_en_o;
    if (task_valid_o && !prev_valid) begin
      obs.push_back('{kind: EV_T, a: int'(task_id_o), d: int'(task_arg_o), cyc: cyc});
      cap_id = task_id_o;
      cap_arg = task_arg_o;
    end else if (task_valid_o && (task_id_o !== cap_id || task_arg_o !== cap_arg)) begin
      stab_viol++;
    end
    prev_valid = task_valid_o;
    if (interrupt_o) obs.push_back('{kind: EV_I, a: 0, d: 0, cyc: cyc});
    if (rst_pulse_o) obs.push_back('{kind: EV_P, a: int'(rst_sel_o), d: 0, cyc: cyc});
    reg_rd_data_i = stub_val[reg_addr_o];
    if (auto_resp) begin
      if (task_ready_i) begin
        task_ready_i = 1'b0;
        busy_pend = 1'b1;
        done_cnt = $urandom_range(0, 3);
      end else if (task_done_i) begin
        task_done_i = 1'b0;
      end else if (busy_pend) begin
        if (done_cnt == 0) begin
          task_done_i = 1'b1;
          busy_pend = 1'b0;
        end else done_cnt--;
      end else if (task_valid_o) begin
        if (rdy_cnt == 0) begin
          task_ready_i = 1'b1;
          rdy_cnt = $urandom_range(0, 3);
        end else rdy_cnt--;
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    cmd_i = '0;
    task_ready_i = 1'b0;
    task_done_i = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({buffer_full_o, overflow_o, rst_sel_o, rst_pulse_o, reg_wr_en_o, reg_addr_o, reg_wr_data_o,
         reg_rd_en_o, data_o, task_valid_o, task_id_o, task_arg_o, interrupt_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got nonzero (full=%b ovf=%b valid=%b data=%h) want all 0",
               buffer_full_o, overflow_o, task_valid_o, data_o);
    end
    rst_i = 1'b0;
    tick();
    obs.delete();
    cmd_i = mk(RESET, RST_ALL, 16'h0);
    tick();
    cmd_i = '0;
    n_cmp++;
    if (rst_pulse_o !== 1'b1 || rst_sel_o !== 4'h0) begin
      n_err++;
      $display("FAIL rst_all_pulse: got pulse=%b sel=%h want pulse=1 sel=0", rst_pulse_o, rst_sel_o);
    end
    n_cmp++;
    if ({reg_wr_en_o, reg_rd_en_o, task_valid_o, interrupt_o, buffer_full_o, overflow_o} !== 6'b0) begin
      n_err++;
      $display("FAIL rst_all_others: got wr=%b rd=%b valid=%b irq=%b full=%b ovf=%b want all 0",
               reg_wr_en_o, reg_rd_en_o, task_valid_o, interrupt_o, buffer_full_o, overflow_o);
    end
    tick();
    n_cmp++;
    if (rst_pulse_o !== 1'b0) begin
      n_err++;
      $display("FAIL rst_all_one_cycle: got pulse=%b want 0", rst_pulse_o);
    end
    repeat (3) tick();
    n_cmp++;
    if (obs.size() != 1) begin
      n_err++;
      $display("FAIL rst_all_queue_empty: got %0d events want 1 (the reset pulse only)", obs.size());
    end
  endtask

  task automatic test_reg_rw();
    cmd_i = mk(WRITE_REG, 4'h3, 16'h00AB);
    tick();
    cmd_i = mk(READ_REG, 4'h3, 16'h0);
    tick();
    cmd_i = '0;
    tick();
    n_cmp++;
    if (reg_wr_en_o !== 1'b1 || reg_addr_o !== 4'h3 || reg_wr_data_o !== 16'h00AB) begin
      n_err++;
      $display("FAIL wr_strobe: got en=%b addr=%h data=%h want en=1 addr=3 data=00ab",
               reg_wr_en_o, reg_addr_o, reg_wr_data_o);
    end
    tick();
    n_cmp++;
    if (reg_wr_en_o !== 1'b0 || reg_rd_en_o !== 1'b0) begin
      n_err++;
      $display("FAIL wr_one_cycle: got wr=%b rd=%b want 0 0", reg_wr_en_o, reg_rd_en_o);
    end
    tick();
    n_cmp++;
    if (reg_rd_en_o !== 1'b1 || reg_addr_o !== 4'h3) begin
      n_err++;
      $display("FAIL rd_strobe: got en=%b addr=%h want en=1 addr=3", reg_rd_en_o, reg_addr_o);
    end
    tick();
    n_cmp++;
    if (data_o !== 16'h00AB || reg_rd_en_o !== 1'b0) begin
      n_err++;
      $display("FAIL rd_data: got data=%h rd=%b want data=00ab rd=0", data_o, reg_rd_en_o);
    end
    repeat (3) tick();
    n_cmp++;
    if (data_o !== 16'h00AB) begin
      n_err++;
      $display("FAIL rd_data_hold: got %h want 00ab", data_o);
    end
  endtask

  // The first command leaves the FIFO for the decoder straight away, so eight
  // more fill it and the tenth is the one dropped.
  task automatic test_overflow();
    int n;
    auto_resp = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cmd_i = mk(START_TASK, WRITE_TO_MEM, 16'(8 * k));
      tick();
      if (k == 8) begin
        n_cmp++;
        if (buffer_full_o !== 1'b1 || overflow_o !== 1'b0) begin
          n_err++;
          $display("FAIL fifo_full: got full=%b ovf=%b want full=1 ovf=0", buffer_full_o, overflow_o);
        end
      end
    end
    cmd_i = '0;
    n_cmp++;
    if (overflow_o !== 1'b1 || buffer_full_o !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_set: got ovf=%b full=%b want 1 1", overflow_o, buffer_full_o);
    end
    for (int i = 0; i < 9; i++) begin
      n = 0;
      while (!task_valid_o && n < 10) begin
        tick();
        n++;
      end
      n_cmp++;
      if (task_valid_o !== 1'b1 || task_id_o !== 4'(WRITE_TO_MEM) || task_arg_o !== 16'(8 * i)) begin
        n_err++;
        $display("FAIL ovf_task[%0d]: got valid=%b id=%h arg=%0d want valid=1 id=4 arg=%0d",
                 i, task_valid_o, task_id_o, task_arg_o, 8 * i);
      end
      task_ready_i = 1'b1;
      tick();
      task_ready_i = 1'b0;
      tick();
      task_done_i = 1'b1;
      tick();
      task_done_i = 1'b0;
      n_cmp++;
      if (interrupt_o !== 1'b1) begin
        n_err++;
        $display("FAIL ovf_irq[%0d]: got %b want 1", i, interrupt_o);
      end
    end
    repeat (6) tick();
    n_cmp++;
    if (task_valid_o !== 1'b0 || buffer_full_o !== 1'b0 || overflow_o !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_drained: got valid=%b full=%b ovf=%b want 0 0 1", task_valid_o, buffer_full_o, overflow_o);
    end
  endtask

  task automatic test_stall();
    int n;
    cmd_i = mk(START_TASK, LOAD_CONV_WEIGHTS, 16'd16);
    tick();
    cmd_i = '0;
    n = 0;
    while (!task_valid_o && n < 10) begin
      tick();
      n++;
    end
    for (int s = 0; s < 5; s++) begin
      n_cmp++;
      if (task_valid_o !== 1'b1 || task_id_o !== 4'h0 || task_arg_o !== 16'd16) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got valid=%b id=%h arg=%0d want 1 0 16", s, task_valid_o, task_id_o, task_arg_o);
      end
      tick();
    end
    task_ready_i = 1'b1;
    tick();
    task_ready_i = 1'b0;
    n_cmp++;
    if (task_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL stall_accept: got valid=%b want 0", task_valid_o);
    end
    tick();
    n_cmp++;
    if (interrupt_o !== 1'b0) begin
      n_err++;
      $display("FAIL stall_early_irq: got %b want 0", interrupt_o);
    end
    task_done_i = 1'b1;
    tick();
    task_done_i = 1'b0;
    n_cmp++;
    if (interrupt_o !== 1'b1) begin
      n_err++;
      $display("FAIL stall_irq: got %b want 1", interrupt_o);
    end
    tick();
    n_cmp++;
    if (interrupt_o !== 1'b0) begin
      n_err++;
      $display("FAIL stall_irq_pulse: got %b want 0", interrupt_o);
    end
  endtask

  task automatic test_rst_all_busy();
    int n;
    int stray;
    n_cmp++;
    if (overflow_o !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_sticky: got %b want 1", overflow_o);
    end
    for (int k = 1; k <= 4; k++) begin
      cmd_i = mk(START_TASK, RUN_DENSE, 16'(k));
      tick();
    end
    cmd_i = '0;
    n = 0;
    while (!task_valid_o && n < 10) begin
      tick();
      n++;
    end
    n_cmp++;
    if (task_valid_o !== 1'b1 || task_arg_o !== 16'd1) begin
      n_err++;
      $display("FAIL busy_first: got valid=%b arg=%0d want 1 1", task_valid_o, task_arg_o);
    end
    task_ready_i = 1'b1;
    tick();
    task_ready_i = 1'b0;
    tick();
    cmd_i = mk(RESET, RST_ALL, 16'h0);
    tick();
    cmd_i = '0;
    n_cmp++;
    if (rst_pulse_o !== 1'b1 || task_valid_o !== 1'b0 || overflow_o !== 1'b0 || buffer_full_o !== 1'b0) begin
      n_err++;
      $display("FAIL busy_rst_all: got pulse=%b valid=%b ovf=%b full=%b want 1 0 0 0",
               rst_pulse_o, task_valid_o, overflow_o, buffer_full_o);
    end
    obs.delete();
    task_done_i = 1'b1;
    tick();
    task_done_i = 1'b0;
    repeat (6) tick();
    stray = 0;
    foreach (obs[i]) if (obs[i].kind == EV_T || obs[i].kind == EV_I) stray++;
    n_cmp++;
    if (stray != 0) begin
      n_err++;
      $display("FAIL busy_flushed: got %0d task/irq events after flush want 0", stray);
    end
  endtask

  task automatic test_discard();
    int c0;
    obs.delete();
    c0 = cyc;
    cmd_i = mk(4'hF, 4'h0, 16'h1234);
    tick();
    cmd_i = mk(START_TASK, 4'h9, 16'h0055);
    tick();
    cmd_i = mk(WRITE_REG, 4'h5, 16'hBEEF);
    tick();
    cmd_i = '0;
    repeat (8) tick();
    n_cmp++;
    if (obs.size() != 1) begin
      n_err++;
      $display("FAIL discard_count: got %0d events want 1", obs.size());
    end
    if (obs.size() > 0) begin
      n_cmp++;
      if (obs[0].kind != EV_W || obs[0].a != 5 || obs[0].d != 16'hBEEF || obs[0].cyc != c0 + 7) begin
        n_err++;
        $display("FAIL discard_write: got kind=%0d a=%0h d=%0h cyc=%0d want kind=1 a=5 d=beef cyc=%0d",
                 obs[0].kind, obs[0].a, obs[0].d, obs[0].cyc, c0 + 7);
      end
    end
  endtask

  // Random bursts; the model lists, in command order, the events each accepted command must produce.
  task automatic test_random();
    int n, nb, r, gap;
    logic [3:0] a;
    logic [15:0] d;
    auto_resp = 1'b1;
    busy_pend = 1'b0;
    task_ready_i = 1'b0;
    task_done_i = 1'b0;
    obs.delete();
    exp_q.delete();
    stab_viol = 0;
    for (int b = 0; b < 40; b++) begin
      nb = $urandom_range(1, 6);
      for (int j = 0; j < nb; j++) begin
        r = $urandom_range(0, 9);
        a = 4'($urandom_range(0, 15));
        d = 16'($urandom);
        if (r <= 2) begin
          cmd_i = mk(WRITE_REG, a, d);
          exp_q.push_back('{kind: EV_W, a: int'(a), d: int'(d), cyc: 0});
        end else if (r <= 4) begin
          cmd_i = mk(READ_REG, a, d);
          exp_q.push_back('{kind: EV_R, a: int'(a), d: 0, cyc: 0});
          exp_q.push_back('{kind: EV_D, a: 0, d: int'(stub_val[a]), cyc: 0});
        end else if (r <= 7) begin
          a = 4'($urandom_range(0, 5));
          cmd_i = mk(START_TASK, a, d);
          exp_q.push_back('{kind: EV_T, a: int'(a), d: int'(d), cyc: 0});
          exp_q.push_back('{kind: EV_I, a: 0, d: 0, cyc: 0});
        end else if (r == 8) begin
          a = 4'($urandom_range(1, 3));
          cmd_i = mk(RESET, a, d);
          exp_q.push_back('{kind: EV_P, a: int'(a), d: 0, cyc: 0});
        end else if ($urandom_range(0, 1) == 0) begin
          cmd_i = mk(4'($urandom_range(5, 15)), a, d);
        end else begin
          cmd_i = mk(START_TASK, 4'($urandom_range(6, 15)), d);
        end
        tick();
        cmd_i = '0;
        gap = $urandom_range(0, 2);
        repeat (gap) tick();
      end
      n = 0;
      while (obs.size() < exp_q.size() && n < 400) begin
        tick();
        n++;
      end
      repeat (3) tick();
      n_cmp++;
      if (n >= 400) begin
        n_err++;
        $display("FAIL rnd_drain[%0d]: got %0d events want %0d within 400 cycles", b, obs.size(), exp_q.size());
      end
    end
    n_cmp++;
    if (obs.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL rnd_count: got %0d events want %0d", obs.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= obs.size()) begin
        n_err++;
        $display("FAIL rnd_ev[%0d]: got none want kind=%0d a=%0h d=%0h", i, exp_q[i].kind, exp_q[i].a, exp_q[i].d);
      end else if (obs[i].kind != exp_q[i].kind || obs[i].a != exp_q[i].a || obs[i].d != exp_q[i].d) begin
        n_err++;
        $display("FAIL rnd_ev[%0d]: got kind=%0d a=%0h d=%0h want kind=%0d a=%0h d=%0h",
                 i, obs[i].kind, obs[i].a, obs[i].d, exp_q[i].kind, exp_q[i].a, exp_q[i].d);
      end
    end
    n_cmp++;
    if (stab_viol != 0 || overflow_o !== 1'b0) begin
      n_err++;
      $display("FAIL rnd_stable: got %0d unstable task cycles ovf=%b want 0 0", stab_viol, overflow_o);
    end
    auto_resp = 1'b0;
  endtask

  initial begin
    reg_rd_data_i = '0;
    rst_i = 1'b1;
    cmd_i = '0;
    task_ready_i = 1'b0;
    task_done_i = 1'b0;
    auto_resp = 1'b0;
    for (int i = 0; i < 16; i++) stub_val[i] = 16'($urandom);
    stub_val[3] = 16'h00AB;
    test_reset();
    test_reg_rw();
    test_overflow();
    test_stall();
    test_rst_all_busy();
    test_discard();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
